mod_147_hb_monitor: RTL

- Receive-side heartbeat supervisor for 10BASE-T1S point-to-point (non-multidrop) operation.
- Watches decoded receive commands (rx_cmd) and receive activity (RX_DV) from the PCS receive path.
- Declares heartbeat link health to PMA/PHY link monitoring: hb_link_ok when the peer's heartbeats or frames arrive within a timeout, a one-cycle hb_lost pulse on loss.
- Complements the heartbeat transmit state machine, which generates hb_cmd.

---
 rtl/mod_147_hb_monitor_if.sv | 26 ++
 rtl/mod_147_hb_monitor.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/mod_147_hb_monitor_if.sv
// Heartbeat monitor bus: PCS/autoneg gating, decoded receive activity and link-health outputs.
interface mod_147_hb_monitor_if #(
    parameter int unsigned CNT_W = 8
);
    logic             pcs_reset;
    logic             mr_autoneg_enable;
    logic             an_link_good;
    logic             multidrop;
    logic [1:0]       rx_cmd;
    logic             RX_DV;
    logic             CRS;
    logic             hb_link_ok;
    logic             hb_lost;
    logic [CNT_W-1:0] hb_count;
    logic [2:0]       hb_mon_state;

    modport master (
        output pcs_reset, mr_autoneg_enable, an_link_good, multidrop, rx_cmd, RX_DV, CRS,
        input  hb_link_ok, hb_lost, hb_count, hb_mon_state
    );

    modport slave (
        input  pcs_reset, mr_autoneg_enable, an_link_good, multidrop, rx_cmd, RX_DV, CRS,
        output hb_link_ok, hb_lost, hb_count, hb_mon_state
    );
endinterface

// File: rtl/mod_147_hb_monitor.sv
// Receive-side heartbeat supervisor for 10BASE-T1S point-to-point links.
// Tracks peer heartbeats / frame starts and reports link health, loss pulses and a heartbeat count.
module mod_147_hb_monitor #(
    parameter int unsigned TMR_W      = 16,
    parameter int unsigned HB_TIMEOUT = 50000,
    parameter int unsigned ACQ_COUNT  = 3,
    parameter int unsigned CNT_W      = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    mod_147_hb_monitor_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'b000,
        ST_ACQUIRE   = 3'b001,
        ST_LINK_OK   = 3'b010,
        ST_LINK_FAIL = 3'b011,
        ST_DISABLED  = 3'b100
    } state_t;

    localparam int unsigned     CONS_W        = 4;
    localparam logic [1:0]      CMD_BEACON    = 2'b00;
    localparam logic [1:0]      CMD_HEARTBEAT = 2'b10;
    localparam logic [TMR_W-1:0]  TIMEOUT_VAL = TMR_W'(HB_TIMEOUT);
    localparam logic [CONS_W-1:0] ACQ_VAL     = CONS_W'(ACQ_COUNT);

    state_t             state, state_nxt;
    logic [TMR_W-1:0]   timer, timer_nxt;
    logic [CONS_W-1:0]  consec, consec_nxt;
    logic [CNT_W-1:0]   hb_count_q, hb_count_nxt;
    logic               hb_lost_q, hb_lost_nxt;
    logic               hb_link_ok_q;
    logic               hb_prev, dv_prev;

    logic               gate_off_c;
    logic               hb_evt_c;
    logic               alive_evt_c;
    logic               timeout_c;
    logic [TMR_W-1:0]   timer_run_c;
    logic [CONS_W-1:0]  consec_inc_c;

    assign gate_off_c   = bus.pcs_reset | ~bus.mr_autoneg_enable | ~bus.an_link_good | bus.multidrop;
    assign hb_evt_c     = (bus.rx_cmd == CMD_HEARTBEAT) & ~hb_prev;
    assign alive_evt_c  = hb_evt_c | (bus.RX_DV & ~dv_prev);
    assign timeout_c    = (timer == TIMEOUT_VAL) & ~alive_evt_c & ~bus.CRS;
    assign consec_inc_c = (consec == '1) ? consec : consec + CONS_W'(1);

    // Idle-running timer: frozen by carrier, stops counting once it reaches the timeout value
    always_comb begin
        timer_run_c = timer;
        if (!bus.CRS && (timer < TIMEOUT_VAL)) begin
            timer_run_c = timer + TMR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            timer        <= '0;
            consec       <= '0;
            hb_count_q   <= '0;
            hb_lost_q    <= 1'b0;
            hb_link_ok_q <= 1'b0;
            hb_prev      <= 1'b0;
            dv_prev      <= 1'b0;
        end else begin
            state        <= state_nxt;
            timer        <= timer_nxt;
            consec       <= consec_nxt;
            hb_count_q   <= hb_count_nxt;
            hb_lost_q    <= hb_lost_nxt;
            hb_link_ok_q <= (state_nxt == ST_LINK_OK);
            hb_prev      <= (bus.rx_cmd == CMD_HEARTBEAT);
            dv_prev      <= bus.RX_DV;
        end
    end

    always_comb begin
        state_nxt    = state;
        timer_nxt    = timer;
        consec_nxt   = consec;
        hb_count_nxt = hb_count_q;
        hb_lost_nxt  = 1'b0;

        if (gate_off_c) begin
            state_nxt    = ST_IDLE;
            timer_nxt    = '0;
            consec_nxt   = '0;
            hb_count_nxt = '0;
        end else if (state == ST_IDLE) begin
            state_nxt  = ST_ACQUIRE;
            timer_nxt  = '0;
            consec_nxt = '0;
        end else begin
            if (hb_evt_c && (hb_count_q != '1)) begin
                hb_count_nxt = hb_count_q + CNT_W'(1);
            end

            if (bus.rx_cmd == CMD_BEACON) begin
                state_nxt = ST_DISABLED;
                timer_nxt = '0;
            end else begin
                case (state)
                    ST_ACQUIRE: begin
                        if (alive_evt_c) begin
                            timer_nxt = '0;
                            if (consec_inc_c >= ACQ_VAL) begin
                                state_nxt  = ST_LINK_OK;
                                consec_nxt = '0;
                            end else begin
                                consec_nxt = consec_inc_c;
                            end
                        end else if (timeout_c) begin
                            timer_nxt  = '0;
                            consec_nxt = '0;
                        end else begin
                            timer_nxt = timer_run_c;
                        end
                    end
                    ST_LINK_OK: begin
                        if (alive_evt_c) begin
                            timer_nxt = '0;
                        end else if (timeout_c) begin
                            state_nxt   = ST_LINK_FAIL;
                            hb_lost_nxt = 1'b1;
                            timer_nxt   = '0;
                        end else begin
                            timer_nxt = timer_run_c;
                        end
                    end
                    ST_LINK_FAIL: begin
                        timer_nxt = '0;
                        if (alive_evt_c) begin
                            if (ACQ_VAL <= CONS_W'(1)) begin
                                state_nxt  = ST_LINK_OK;
                                consec_nxt = '0;
                            end else begin
                                state_nxt  = ST_ACQUIRE;
                                consec_nxt = CONS_W'(1);
                            end
                        end
                    end
                    ST_DISABLED: begin
                        timer_nxt = '0;
                    end
                    default: begin
                        state_nxt = ST_IDLE;
                        timer_nxt = '0;
                    end
                endcase
            end
        end
    end

    assign bus.hb_link_ok   = hb_link_ok_q;
    assign bus.hb_lost      = hb_lost_q;
    assign bus.hb_count     = hb_count_q;
    assign bus.hb_mon_state = state;

endmodule
